pipe_ctrl: RTL

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 26 ++
 rtl/pipe_ctrl_if.sv | 39 +++
 rtl/pipe_hazard_cmp.sv | 14 +
 rtl/pipe_ctrl.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared widths, FSM state encoding, timeout default and the load-use
// compare helper for the pipeline controller.
package pipe_ctrl_pkg;

  localparam int WIDTH           = 16;
  localparam int R_WIDTH         = 5;
  localparam int MEM_TIMEOUT_DEF = 15;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERR      = 2'd2
  } pipe_state_e;

  // A load in EX blocks ID when it writes a non-zero register that ID reads.
  function automatic logic load_use_hit(
    input logic               ex_mem_read,
    input logic [R_WIDTH-1:0] ex_rt,
    input logic [R_WIDTH-1:0] id_rs,
    input logic [R_WIDTH-1:0] id_rt
  );
    return ex_mem_read && (ex_rt != R_WIDTH'(0)) &&
           ((ex_rt == id_rs) || (ex_rt == id_rt));
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard/memory status from the pipeline and stage-register controls back
// to it; slave is the controller side, master the datapath side.
interface pipe_ctrl_if
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = WIDTH
);
  logic [R_WIDTH-1:0] id_rs_i;
  logic [R_WIDTH-1:0] id_rt_i;
  logic               ex_mem_read_i;
  logic [R_WIDTH-1:0] ex_rt_i;
  logic               ex_branch_taken_i;
  logic               mem_req_i;
  logic               mem_ready_i;
  logic               pc_en_o;
  logic               if_id_en_o;
  logic               id_ex_en_o;
  logic               ex_mem_en_o;
  logic               if_id_flush_o;
  logic               id_ex_flush_o;
  logic               mem_wb_bubble_o;
  logic               mem_busy_o;
  logic               mem_err_o;
  logic [CNT_W-1:0]   stall_cnt_o;

  modport slave (
    input  id_rs_i, id_rt_i, ex_mem_read_i, ex_rt_i, ex_branch_taken_i,
           mem_req_i, mem_ready_i,
    output pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o, if_id_flush_o,
           id_ex_flush_o, mem_wb_bubble_o, mem_busy_o, mem_err_o, stall_cnt_o
  );

  modport master (
    output id_rs_i, id_rt_i, ex_mem_read_i, ex_rt_i, ex_branch_taken_i,
           mem_req_i, mem_ready_i,
    input  pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o, if_id_flush_o,
           id_ex_flush_o, mem_wb_bubble_o, mem_busy_o, mem_err_o, stall_cnt_o
  );
endinterface

// File: rtl/pipe_hazard_cmp.sv
// Combinational load-use detector between the load in EX and the ID operands.
module pipe_hazard_cmp
  import pipe_ctrl_pkg::*;
(
  input  logic               ex_mem_read_i,
  input  logic [R_WIDTH-1:0] ex_rt_i,
  input  logic [R_WIDTH-1:0] id_rs_i,
  input  logic [R_WIDTH-1:0] id_rt_i,
  output logic               hazard_o
);

  assign hazard_o = load_use_hit(ex_mem_read_i, ex_rt_i, id_rs_i, id_rt_i);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: memory-wait FSM with timeout error,
// branch flush, load-use stall and a saturating stall-cycle counter.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int CNT_W       = WIDTH
)(
  input  logic          clk_i,
  input  logic          rst_n_i,
  pipe_ctrl_if.slave    bus
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 2);

  pipe_state_e       state_r;
  pipe_state_e       state_nxt_s;
  logic [WAIT_W-1:0] wait_r;
  logic [WAIT_W-1:0] wait_nxt_s;
  logic [CNT_W-1:0]  stall_r;
  logic              err_r;
  logic              hazard_s;

  logic pc_en_s;
  logic if_id_en_s;
  logic id_ex_en_s;
  logic ex_mem_en_s;
  logic if_id_flush_s;
  logic id_ex_flush_s;
  logic mem_wb_bubble_s;

  pipe_hazard_cmp u_hazard_cmp (
    .ex_mem_read_i (bus.ex_mem_read_i),
    .ex_rt_i       (bus.ex_rt_i),
    .id_rs_i       (bus.id_rs_i),
    .id_rt_i       (bus.id_rt_i),
    .hazard_o      (hazard_s)
  );

  // Next-state, wait counter and stage controls from state and inputs
  always_comb begin
    state_nxt_s     = state_r;
    wait_nxt_s      = wait_r;
    pc_en_s         = 1'b1;
    if_id_en_s      = 1'b1;
    id_ex_en_s      = 1'b1;
    ex_mem_en_s     = 1'b1;
    if_id_flush_s   = 1'b0;
    id_ex_flush_s   = 1'b0;
    mem_wb_bubble_s = 1'b0;

    case (state_r)
      ST_RUN: begin
        if (bus.mem_req_i && !bus.mem_ready_i) begin
          pc_en_s         = 1'b0;
          if_id_en_s      = 1'b0;
          id_ex_en_s      = 1'b0;
          ex_mem_en_s     = 1'b0;
          mem_wb_bubble_s = 1'b1;
          state_nxt_s     = ST_MEM_WAIT;
          wait_nxt_s      = WAIT_W'(1);
        end else if (bus.ex_branch_taken_i) begin
          if_id_flush_s = 1'b1;
          id_ex_flush_s = 1'b1;
        end else if (hazard_s) begin
          pc_en_s       = 1'b0;
          if_id_en_s    = 1'b0;
          id_ex_flush_s = 1'b1;
        end else begin
          wait_nxt_s = WAIT_W'(0);
        end
      end
      ST_MEM_WAIT: begin
        // Ready wins over timeout: the access completes this cycle.
        if (bus.mem_ready_i) begin
          state_nxt_s = ST_RUN;
          wait_nxt_s  = WAIT_W'(0);
        end else begin
          pc_en_s         = 1'b0;
          if_id_en_s      = 1'b0;
          id_ex_en_s      = 1'b0;
          ex_mem_en_s     = 1'b0;
          mem_wb_bubble_s = 1'b1;
          wait_nxt_s      = wait_r + WAIT_W'(1);
          if (wait_r == WAIT_W'(MEM_TIMEOUT)) begin
            state_nxt_s = ST_ERR;
          end else begin
            state_nxt_s = ST_MEM_WAIT;
          end
        end
      end
      ST_ERR: begin
        pc_en_s         = 1'b0;
        if_id_en_s      = 1'b0;
        id_ex_en_s      = 1'b0;
        ex_mem_en_s     = 1'b0;
        mem_wb_bubble_s = 1'b1;
      end
      default: begin
        pc_en_s         = 1'b0;
        if_id_en_s      = 1'b0;
        id_ex_en_s      = 1'b0;
        ex_mem_en_s     = 1'b0;
        mem_wb_bubble_s = 1'b1;
        state_nxt_s     = ST_ERR;
      end
    endcase
  end

  // State and wait counter capture on the pipeline-register (falling) edge
  always_ff @(negedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r <= ST_RUN;
      wait_r  <= WAIT_W'(0);
    end else begin
      state_r <= state_nxt_s;
      wait_r  <= wait_nxt_s;
    end
  end

  // Saturating stall counter and sticky timeout flag
  always_ff @(negedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_r <= CNT_W'(0);
      err_r   <= 1'b0;
    end else begin
      if (!pc_en_s && (stall_r != {CNT_W{1'b1}})) begin
        stall_r <= stall_r + CNT_W'(1);
      end
      if (state_nxt_s == ST_ERR) begin
        err_r <= 1'b1;
      end
    end
  end

  // Reset gates every control low so nothing captures during reset.
  assign bus.pc_en_o         = rst_n_i & pc_en_s;
  assign bus.if_id_en_o      = rst_n_i & if_id_en_s;
  assign bus.id_ex_en_o      = rst_n_i & id_ex_en_s;
  assign bus.ex_mem_en_o     = rst_n_i & ex_mem_en_s;
  assign bus.if_id_flush_o   = rst_n_i & if_id_flush_s;
  assign bus.id_ex_flush_o   = rst_n_i & id_ex_flush_s;
  assign bus.mem_wb_bubble_o = rst_n_i & mem_wb_bubble_s;
  assign bus.mem_busy_o      = rst_n_i & (state_r == ST_MEM_WAIT);
  assign bus.mem_err_o       = err_r;
  assign bus.stall_cnt_o     = stall_r;

endmodule
